// File: rtl/aq_djpeg_frame_ctrl.sv
// ---------------------------------------------------------------------------
// aq_djpeg_frame_ctrl
//
// Frame sequencer in front of the JPEG decoder core. It takes one frame
// command at a time. The command gives the frame length in 32-bit words.
// While a frame is active, the block gates source-FIFO words into the decoder.
// It watches the decoder pixel and idle outputs for end of frame, and pops
// any trailing words the decoder did not consume. On a progressive stream or
// a stall it pulses a soft reset into the decoder. A per-frame status is
// reported at the end of each frame.
//
// Parameters
//   TIMEOUT     stall limit in cycles (no word accepted, no pixel output)
//   RST_CYCLES  length of the decoder soft-reset pulse in cycles
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   CmdValid/CmdReady        frame command handshake
//   CmdWords[23:0]           frame length in 32-bit words
//   SrcData/SrcValid/SrcRead source FIFO data, not-empty and pop
//   DecData/DecEnable        decoder DataIn / DataInEnable
//   DecRead                  decoder DataInRead
//   DecRst                   decoder reset (also held high while rst is high)
//   JpegDecodeIdle           decoder idle
//   JpegProgressive          decoder found a progressive frame
//   OutEnable                decoder pixel valid
//   OutWidth/OutHeight       decoded image size
//   OutPixelX/OutPixelY      current pixel coordinates
//   Busy                     sequencer not idle
//   FrameDone                one-cycle end-of-frame pulse
//   FrameError               FrameDone qualifier, held until next command
//   ErrCode[1:0]             0 ok, 1 progressive, 2 timeout, 3 zero length
//   PixelCount[31:0]         saturating count of pixels in the current frame
//
// Build option
//   AQ_DJPEG_FRAME_CTRL_TIMEOUT_EN  when defined, the stall watchdog and the
//   ErrCode=2 paths are built. When undefined, a stalled frame waits in
//   FEED or FLUSH until rst.
// ---------------------------------------------------------------------------
module aq_djpeg_frame_ctrl #(
   parameter int unsigned TIMEOUT    = 1000000,
   parameter int unsigned RST_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        CmdValid,
   output logic        CmdReady,
   input  logic [23:0] CmdWords,
   input  logic [31:0] SrcData,
   input  logic        SrcValid,
   output logic        SrcRead,
   output logic [31:0] DecData,
   output logic        DecEnable,
   input  logic        DecRead,
   output logic        DecRst,
   input  logic        JpegDecodeIdle,
   input  logic        JpegProgressive,
   input  logic        OutEnable,
   input  logic [15:0] OutWidth,
   input  logic [15:0] OutHeight,
   input  logic [15:0] OutPixelX,
   input  logic [15:0] OutPixelY,
   output logic        Busy,
   output logic        FrameDone,
   output logic        FrameError,
   output logic [1:0]  ErrCode,
   output logic [31:0] PixelCount
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FEED,
      S_FLUSH,
      S_SRST,
      S_DONE
   } state_t;

   localparam int RC_W = $clog2(RST_CYCLES + 1);

   state_t            state_q, state_d;
   logic [23:0]       words_left_q, words_left_d;
   logic [31:0]       pix_cnt_q, pix_cnt_d;
   logic              last_pix_q, last_pix_d;
   logic              started_q, started_d;
   logic [1:0]        err_code_q, err_code_d;
   logic              frame_error_q, frame_error_d;
   logic              dec_rst_q, dec_rst_d;
   logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;

   logic              cmd_ready;
   logic              dec_enable;
   logic              src_read;
   logic              pix_is_last;
   logic              timeout_ev;

   // Word gating is kept separate from the state logic.
   // The watchdog reads the pop strobe, and the state logic reads the watchdog.
   always_comb begin
      cmd_ready  = (state_q == S_IDLE);
      dec_enable = (state_q == S_FEED) && SrcValid && (words_left_q != 24'd0);
      src_read   = (dec_enable && DecRead) || ((state_q == S_FLUSH) && SrcValid);
   end

   assign pix_is_last = (OutPixelX == OutWidth - 16'd1) &&
                        (OutPixelY == OutHeight - 16'd1);

`ifdef AQ_DJPEG_FRAME_CTRL_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] wdog_q, wdog_d;
   logic            wd_active;
   logic            wd_activity;

   assign wd_active   = (state_q == S_FEED) || (state_q == S_FLUSH);
   assign wd_activity = src_read || OutEnable;

   // The timeout fires in the idle cycle in which the count would reach
   // TIMEOUT. Every timeout leaves FEED/FLUSH, so the counter never wraps.
   assign timeout_ev = wd_active && !wd_activity &&
                       (wdog_q == WD_W'(TIMEOUT - 1));

   always_comb begin
      wdog_d = wdog_q;
      if (!wd_active || wd_activity || (state_d != state_q)) begin
         wdog_d = '0;
      end else begin
         wdog_d = wdog_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`else
   // No watchdog in this build. TIMEOUT is still referenced here.
   // This keeps one parameter list that works for both builds.
   assign timeout_ev = (TIMEOUT == 0) && 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      words_left_d  = words_left_q;
      pix_cnt_d     = pix_cnt_q;
      last_pix_d    = last_pix_q;
      started_d     = started_q;
      err_code_d    = err_code_q;
      frame_error_d = frame_error_q;
      rst_cnt_d     = rst_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (CmdValid) begin
               err_code_d    = 2'd0;
               frame_error_d = 1'b0;
               pix_cnt_d     = 32'd0;
               last_pix_d    = 1'b0;
               started_d     = 1'b0;
               words_left_d  = CmdWords;
               if (CmdWords != 24'd0) begin
                  state_d = S_FEED;
               end else begin
                  state_d    = S_DONE;
                  err_code_d = 2'd3;
               end
            end
         end

         S_FEED: begin
            if (src_read) begin
               words_left_d = words_left_q - 24'd1;
            end
            if (!JpegDecodeIdle) begin
               started_d = 1'b1;
            end
            if (OutEnable && pix_is_last) begin
               last_pix_d = 1'b1;
            end
            if (OutEnable && (pix_cnt_q != 32'hFFFF_FFFF)) begin
               pix_cnt_d = pix_cnt_q + 32'd1;
            end

            if (JpegProgressive) begin
               state_d    = S_SRST;
               err_code_d = 2'd1;
               rst_cnt_d  = '0;
            end else if (timeout_ev) begin
               state_d    = S_SRST;
               err_code_d = 2'd2;
               rst_cnt_d  = '0;
            end else if (last_pix_q && started_q && JpegDecodeIdle) begin
               // Use the post-pop count: a final pop in this cycle leaves nothing to flush.
               state_d = (words_left_d != 24'd0) ? S_FLUSH : S_DONE;
            end
         end

         S_FLUSH: begin
            if (src_read) begin
               words_left_d = words_left_q - 24'd1;
               if (words_left_q == 24'd1) begin
                  state_d = S_DONE;
               end
            end else if (timeout_ev) begin
               // The decoder is already reset or finished; drop the rest.
               state_d    = S_DONE;
               err_code_d = 2'd2;
            end
         end

         S_SRST: begin
            if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
               state_d = (words_left_q != 24'd0) ? S_FLUSH : S_DONE;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
         frame_error_d = (err_code_d != 2'd0);
      end
   end

   // DecRst is high for exactly the SRST cycles and for the reset period.
   assign dec_rst_d = (state_d == S_SRST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         words_left_q  <= 24'd0;
         pix_cnt_q     <= 32'd0;
         last_pix_q    <= 1'b0;
         started_q     <= 1'b0;
         err_code_q    <= 2'd0;
         frame_error_q <= 1'b0;
         dec_rst_q     <= 1'b1;
         rst_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         words_left_q  <= words_left_d;
         pix_cnt_q     <= pix_cnt_d;
         last_pix_q    <= last_pix_d;
         started_q     <= started_d;
         err_code_q    <= err_code_d;
         frame_error_q <= frame_error_d;
         dec_rst_q     <= dec_rst_d;
         rst_cnt_q     <= rst_cnt_d;
      end
   end

   assign CmdReady   = cmd_ready;
   assign DecEnable  = dec_enable;
   assign SrcRead    = src_read;
   assign DecData    = SrcData;
   assign DecRst     = dec_rst_q;
   assign Busy       = (state_q != S_IDLE);
   assign FrameDone  = (state_q == S_DONE);
   assign FrameError = frame_error_q;
   assign ErrCode    = err_code_q;
   assign PixelCount = pix_cnt_q;

endmodule

// File: tb/tb_aq_djpeg_frame_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for aq_djpeg_frame_ctrl.
// It runs a table of frame scenarios against a small behavioural decoder
// model. A 16x16 image gives 256 pixels. Hand-written sequences cover reset
// values, reset in the middle of a frame, and stalls.
// ---------------------------------------------------------------------------
module tb_aq_djpeg_frame_ctrl;

   logic        clk;
   logic        rst;
   logic        CmdValid;
   logic        CmdReady;
   logic [23:0] CmdWords;
   logic [31:0] SrcData;
   logic        SrcValid;
   logic        SrcRead;
   logic [31:0] DecData;
   logic        DecEnable;
   logic        DecRead;
   logic        DecRst;
   logic        JpegDecodeIdle;
   logic        JpegProgressive;
   logic        OutEnable;
   logic [15:0] OutWidth;
   logic [15:0] OutHeight;
   logic [15:0] OutPixelX;
   logic [15:0] OutPixelY;
   logic        Busy;
   logic        FrameDone;
   logic        FrameError;
   logic [1:0]  ErrCode;
   logic [31:0] PixelCount;

   aq_djpeg_frame_ctrl #(
      .TIMEOUT    (64),
      .RST_CYCLES (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .CmdValid        (CmdValid),
      .CmdReady        (CmdReady),
      .CmdWords        (CmdWords),
      .SrcData         (SrcData),
      .SrcValid        (SrcValid),
      .SrcRead         (SrcRead),
      .DecData         (DecData),
      .DecEnable       (DecEnable),
      .DecRead         (DecRead),
      .DecRst          (DecRst),
      .JpegDecodeIdle  (JpegDecodeIdle),
      .JpegProgressive (JpegProgressive),
      .OutEnable       (OutEnable),
      .OutWidth        (OutWidth),
      .OutHeight       (OutHeight),
      .OutPixelX       (OutPixelX),
      .OutPixelY       (OutPixelY),
      .Busy            (Busy),
      .FrameDone       (FrameDone),
      .FrameError      (FrameError),
      .ErrCode         (ErrCode),
      .PixelCount      (PixelCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Running event counters. They are sampled at the falling edge, while the
   // inputs are stable.
   int n_pop  = 0;
   int n_fed  = 0;
   int n_drst = 0;
   int n_done = 0;
   int cyc_g  = 0;

   always @(posedge clk) cyc_g <= cyc_g + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (SrcRead)              n_pop  <= n_pop + 1;
         if (SrcRead && DecEnable) n_fed  <= n_fed + 1;
         if (DecRst)               n_drst <= n_drst + 1;
         if (FrameDone)            n_done <= n_done + 1;
      end
   end

   typedef struct {
      int cmd;       // CmdWords
      int consume;   // words the decoder takes (or words before progressive)
      bit prog;      // decoder reports progressive after 'consume' words
      bit gap;       // SrcValid toggles every cycle
      int err;       // expected ErrCode
      int pix;       // expected PixelCount
      int pops;      // expected SrcRead pops
      int fed;       // expected words delivered to the decoder
      int drst;      // expected DecRst cycles
      int done_off;  // FrameDone cycle minus decoder-idle cycle (-1 = skip)
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic quiet_inputs();
      CmdValid        = 1'b0;
      CmdWords        = 24'd0;
      SrcData         = 32'd0;
      SrcValid        = 1'b0;
      DecRead         = 1'b0;
      JpegDecodeIdle  = 1'b1;
      JpegProgressive = 1'b0;
      OutEnable       = 1'b0;
      OutPixelX       = 16'd0;
      OutPixelY       = 16'd0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input int words);
      CmdValid = 1'b1;
      CmdWords = 24'(words);
      @(negedge clk);
      chk("cmd_ready", 32'(CmdReady), 32'd1);
      next_cycle();
      CmdValid = 1'b0;
   endtask

   // Plays one frame with the decoder model. Phases:
   // 0 feed words, 1 output pixels, 2 idle (completion/flush),
   // 3 progressive report, 4 idle after progressive.
   task automatic run_frame(input vec_t v, input string tag);
      int  phase, consumed, pix, cyc, p2_start;
      int  pop0, fed0, drst0;
      bit  seen;
      phase = 0; consumed = 0; pix = 0; cyc = 0; p2_start = 0; seen = 1'b0;
      send_cmd(v.cmd);
      pop0 = n_pop; fed0 = n_fed; drst0 = n_drst;
      if (v.consume == 0) phase = 2;
      while (cyc < 4000) begin
         SrcData         = $urandom;
         SrcValid        = v.gap ? (cyc % 2 == 1) : 1'b1;
         DecRead         = (phase == 0);
         JpegDecodeIdle  = (phase == 0) ? (consumed == 0) : (phase == 2 || phase == 4);
         JpegProgressive = (phase == 3);
         OutEnable       = (phase == 1 || phase == 3);
         OutPixelX       = (phase == 1) ? 16'(pix % 16) : 16'd0;
         OutPixelY       = (phase == 1) ? 16'(pix / 16) : 16'd0;
         @(negedge clk);
         if (DecEnable) chk({tag, "_dec_data"}, DecData, SrcData);
         if (FrameDone) begin
            seen = 1'b1;
            break;
         end
         case (phase)
            0: begin
               if (SrcRead && DecEnable) consumed++;
               if (consumed == v.consume) phase = v.prog ? 3 : 1;
            end
            1: begin
               pix++;
               if (pix == 256) begin
                  phase    = 2;
                  p2_start = cyc + 1;
               end
            end
            3: phase = 4;
            default: ;
         endcase
         next_cycle();
         cyc++;
      end
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      chk({tag, "_err_code"}, 32'(ErrCode), 32'(v.err));
      chk({tag, "_frame_error"}, 32'(FrameError), 32'(v.err != 0));
      chk({tag, "_pixel_count"}, PixelCount, 32'(v.pix));
      chk({tag, "_pops"}, 32'(n_pop - pop0), 32'(v.pops));
      chk({tag, "_fed"}, 32'(n_fed - fed0), 32'(v.fed));
      chk({tag, "_drst_cycles"}, 32'(n_drst - drst0), 32'(v.drst));
      if (v.done_off >= 0) chk({tag, "_done_latency"}, 32'(cyc - p2_start), 32'(v.done_off));
      next_cycle();
      quiet_inputs();
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 32'(FrameDone), 32'd0);
      chk({tag, "_idle_after_done"}, 32'({Busy, CmdReady}), 32'b01);
      chk({tag, "_frame_error_held"}, 32'(FrameError), 32'(v.err != 0));
      next_cycle();
   endtask

   // Start a frame, feed n words, then stop supplying words.
   task automatic start_and_feed(input int words, input int n, output int last_pop_cyc);
      int consumed;
      consumed = 0;
      last_pop_cyc = 0;
      send_cmd(words);
      for (int i = 0; i < 100 && consumed < n; i++) begin
         SrcData = $urandom; SrcValid = 1'b1; DecRead = 1'b1;
         JpegDecodeIdle = (consumed == 0);
         @(negedge clk);
         if (SrcRead) begin
            consumed++;
            last_pop_cyc = cyc_g;
         end
         next_cycle();
      end
      chk("stall_words_fed", 32'(consumed), 32'(n));
      SrcValid = 1'b0;
      JpegDecodeIdle = 1'b0;
   endtask

   initial begin
      int lp, t0, pop0, cnt;
      bit hit;
      tbl[0] = '{cmd:300, consume:300, prog:0, gap:0, err:0, pix:256, pops:300, fed:300, drst:0,  done_off:1};
      tbl[1] = '{cmd:310, consume:300, prog:0, gap:0, err:0, pix:256, pops:310, fed:300, drst:0,  done_off:11};
      tbl[2] = '{cmd:301, consume:300, prog:0, gap:0, err:0, pix:256, pops:301, fed:300, drst:0,  done_off:2};
      tbl[3] = '{cmd:200, consume:5,   prog:1, gap:0, err:1, pix:1,   pops:200, fed:5,   drst:16, done_off:-1};
      tbl[4] = '{cmd:5,   consume:5,   prog:1, gap:0, err:1, pix:1,   pops:5,   fed:5,   drst:16, done_off:-1};
      tbl[5] = '{cmd:0,   consume:0,   prog:0, gap:0, err:3, pix:0,   pops:0,   fed:0,   drst:0,  done_off:0};
      tbl[6] = '{cmd:300, consume:300, prog:0, gap:1, err:0, pix:256, pops:300, fed:300, drst:0,  done_off:1};

      OutWidth  = 16'd16;
      OutHeight = 16'd16;
      quiet_inputs();
      SrcValid = 1'b1;
      rst = 1'b1;

      // Reset values, with SrcValid high to show DecEnable stays low.
      #12;
      chk("rst_dec_rst", 32'(DecRst), 32'd1);
      chk("rst_frame_done", 32'(FrameDone), 32'd0);
      chk("rst_frame_error", 32'(FrameError), 32'd0);
      chk("rst_err_code", 32'(ErrCode), 32'd0);
      chk("rst_pixel_count", PixelCount, 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_cmd_ready", 32'(CmdReady), 32'd1);
      chk("rst_dec_enable", 32'(DecEnable), 32'd0);
      chk("rst_src_read", 32'(SrcRead), 32'd0);
      next_cycle();
      rst = 1'b0;
      SrcValid = 1'b0;
      @(negedge clk);
      chk("dec_rst_before_edge", 32'(DecRst), 32'd1);
      next_cycle();
      @(negedge clk);
      chk("dec_rst_after_edge", 32'(DecRst), 32'd0);
      next_cycle();

      for (int i = 0; i < 7; i++) begin
         run_frame(tbl[i], $sformatf("vec%0d", i));
      end

`ifdef AQ_DJPEG_FRAME_CTRL_TIMEOUT_EN
      // Stall: 10 of 20 words, then no source data. Expect the watchdog, a
      // soft reset, and a flush of the remaining 10 words.
      pop0 = n_pop;
      start_and_feed(20, 10, lp);
      hit = 1'b0;
      t0 = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (DecRst) begin
            hit = 1'b1;
            t0 = cyc_g;
            break;
         end
         next_cycle();
      end
      chk("stall_srst_seen", 32'(hit), 32'd1);
      chk("stall_srst_delay", 32'(t0 - lp), 32'd65);
      chk("stall_err_code", 32'(ErrCode), 32'd2);
      cnt = 0;
      for (int i = 0; i < 40 && DecRst; i++) begin
         cnt++;
         next_cycle();
         @(negedge clk);
      end
      chk("stall_drst_cycles", 32'(cnt), 32'd16);
      next_cycle();
      SrcValid = 1'b1;
      JpegDecodeIdle = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (FrameDone) begin
            hit = 1'b1;
            break;
         end
         next_cycle();
      end
      chk("stall_done_seen", 32'(hit), 32'd1);
      chk("stall_done_err", 32'(ErrCode), 32'd2);
      chk("stall_done_frame_error", 32'(FrameError), 32'd1);
      chk("stall_pops", 32'(n_pop - pop0), 32'd20);
      next_cycle();
      quiet_inputs();
      next_cycle();
`else
      // Without the watchdog, a stalled frame waits until rst.
      start_and_feed(20, 10, lp);
      for (int i = 0; i < 200; i++) next_cycle();
      @(negedge clk);
      chk("stall_still_busy", 32'(Busy), 32'd1);
      chk("stall_no_srst", 32'(DecRst), 32'd0);
      chk("stall_no_err", 32'(ErrCode), 32'd0);
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      quiet_inputs();
      next_cycle();
`endif

      // Reset in the middle of a frame. It aborts at once, clears state and
      // raises DecRst. No FrameDone is issued.
      start_and_feed(300, 5, lp);
      DecRead = 1'b0;
      OutEnable = 1'b1;
      for (int i = 0; i < 3; i++) next_cycle();
      OutEnable = 1'b0;
      @(negedge clk);
      chk("mid_pixel_count", PixelCount, 32'd3);
      next_cycle();
      t0 = n_done;
      rst = 1'b1;
      #2;
      chk("mid_rst_busy", 32'(Busy), 32'd0);
      chk("mid_rst_dec_rst", 32'(DecRst), 32'd1);
      chk("mid_rst_pixel_count", PixelCount, 32'd0);
      chk("mid_rst_frame_done", 32'(FrameDone), 32'd0);
      chk("mid_rst_cmd_ready", 32'(CmdReady), 32'd1);
      next_cycle();
      rst = 1'b0;
      quiet_inputs();
      for (int i = 0; i < 4; i++) next_cycle();
      @(negedge clk);
      chk("mid_rst_no_done", 32'(n_done - t0), 32'd0);
      chk("mid_rst_idle", 32'(Busy), 32'd0);
      next_cycle();
      run_frame(tbl[0], "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Hard stop if something never returns.
   initial begin
      #2000000;
      $display("FAIL global_timeout: got 0, expected 1");
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/aq_djpeg_frame_ctrl.md
# aq_djpeg_frame_ctrl

Frame sequencer in front of the JPEG decoder core. It accepts one frame command (length in 32-bit words) at a time and gates the word stream from the source FIFO into the decoder's data input. It detects frame completion from the decoder's pixel and idle outputs, flushes unused trailing words, and recovers from progressive streams or stalls by pulsing a soft reset into the decoder. Status is reported per frame.

## Interface
Parameters:
- TIMEOUT, 1000000: stall limit in cycles with no word accepted and no pixel output.
- RST_CYCLES, 16: length of the decoder soft-reset pulse in cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- CmdValid  in  1  frame command valid.
- CmdReady  out  1  command accepted when CmdValid && CmdReady.
- CmdWords  in  24  frame length in 32-bit words.
- SrcData  in  32  source FIFO data.
- SrcValid  in  1  source FIFO not empty.
- SrcRead  out  1  source FIFO pop.
- DecData  out  32  to decoder DataIn; equals SrcData.
- DecEnable  out  1  to decoder DataInEnable.
- DecRead  in  1  from decoder DataInRead.
- DecRst  out  1  decoder reset; the top drives the decoder rst from this.
- JpegDecodeIdle  in  1  decoder idle.
- JpegProgressive  in  1  decoder detected a progressive frame.
- OutEnable  in  1  decoder pixel valid.
- OutWidth, OutHeight  in  16  decoded image size.
- OutPixelX, OutPixelY  in  16  current pixel coordinates.
- Busy  out  1  state != IDLE.
- FrameDone  out  1  one-cycle end-of-frame pulse.
- FrameError  out  1  qualifies FrameDone; held until the next command is accepted.
- ErrCode  out  2  0 ok, 1 progressive, 2 timeout, 3 zero-length command.
- PixelCount  out  32  OutEnable cycles counted in the current frame; saturates at 2^32-1.

## Operation
States: IDLE, FEED, FLUSH, SRST, DONE.

- **IDLE**
  - CmdReady=1.
  - Accepting a command clears ErrCode, FrameError, PixelCount, LastPix and Started, and loads WordsLeft=CmdWords.
  - If CmdWords!=0, go to FEED.
  - If CmdWords==0, go to DONE with ErrCode=3.
- **FEED**
  - DecEnable = SrcValid && WordsLeft!=0.
  - SrcRead = DecEnable && DecRead.
  - WordsLeft decrements on each SrcRead.
  - Started sets on the first cycle with JpegDecodeIdle==0.
  - LastPix sets on OutEnable with OutPixelX==OutWidth-1 and OutPixelY==OutHeight-1.
  - Transitions, highest priority first:
    1. JpegProgressive: go to SRST with ErrCode=1.
    2. Timeout: go to SRST with ErrCode=2.
    3. LastPix && Started && JpegDecodeIdle: go to FLUSH if WordsLeft!=0, else DONE.
  - WordsLeft==0 without completion: remain in FEED with DecEnable=0; only the watchdog exits.
- **FLUSH**
  - DecEnable=0; SrcRead=SrcValid; WordsLeft decrements on each pop.
  - A pop with WordsLeft==1 goes to DONE.
- **SRST**
  - DecRst=1 for RST_CYCLES cycles; DecEnable=0; SrcRead=0.
  - Then go to FLUSH if WordsLeft!=0, else DONE.
- **DONE**
  - FrameDone=1 for one cycle; FrameError=(ErrCode!=0).
  - Next state IDLE.
- **Watchdog**
  - Counter clears on SrcRead or OutEnable, and on entry to FEED or FLUSH.
  - Counts in FEED and FLUSH; reaching TIMEOUT is the timeout event.
  - A timeout in FLUSH goes to DONE with ErrCode=2 (the decoder is already reset or finished).
- **Pixel counting:** PixelCount increments on OutEnable in FEED only.

## Timing
- **Reset values:**
  - state IDLE; DecRst=1; FrameDone=0; FrameError=0; ErrCode=0; PixelCount=0; Busy=0.
  - CmdReady=1 and DecEnable=0 (combinational from state).
  - DecRst falls at the first clk edge after rst deasserts.
- **Combinational outputs:** CmdReady, DecEnable, SrcRead and DecData are combinational from state and inputs; there is no added latency on the data path.
- **Command start:** command accepted at edge N puts FEED in effect from cycle N+1.
- **Completion:** completion condition true in cycle M gives DONE (FrameDone=1) in cycle M+1 and IDLE in M+2.
  - A new command is accepted at the earliest in M+2.
- **Simultaneous events in FEED:** progressive beats timeout beats completion. A word pop in the same cycle as a transition still decrements WordsLeft.
- **Pixel on a transition cycle:** an OutEnable in the cycle FEED exits is still counted.
- **Reset mid-operation:** rst at any time aborts immediately. FrameDone is not issued for the aborted frame, and unconsumed source words are not flushed.

## Configuration
- AQ_DJPEG_FRAME_CTRL_TIMEOUT_EN
  - Defined: watchdog counter and ErrCode=2 paths are present.
  - Undefined: no counter logic. Timeout never fires and ErrCode=2 is never produced; a stalled frame stays in FEED or FLUSH until rst.

## Test plan
- **Baseline decode.** 16x16 baseline frame of 300 words, CmdWords=300 → FrameDone with FrameError=0, ErrCode=0, PixelCount=256, exactly 300 SrcRead pops.
- **Trailing flush.** Same frame with CmdWords=310 → decoder completes after 300 words. FLUSH pops the remaining 10 without DecEnable, then FrameDone, ErrCode=0.
- **Progressive abort.** Progressive stream, CmdWords=200 → DecRst high exactly RST_CYCLES=16 cycles, remaining words flushed, FrameDone with ErrCode=1.
- **Stall timeout.** TIMEOUT=64, SrcValid held 0 after 10 words (macro defined) → SRST after 64 idle cycles, then FLUSH; SrcValid released, remainder flushed; FrameDone with ErrCode=2.
- **Zero-length command.** CmdWords=0 → FrameDone in the cycle after acceptance, ErrCode=3, no SrcRead.
- **Reset mid-frame.** rst pulsed mid-FEED → state IDLE, DecRst=1, PixelCount=0, no FrameDone. A following 16x16 frame of 300 words decodes with ErrCode=0.
